uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one byte-level UART transmitter among up to four requesters, e.g. a command responder, a status reporter and a debug dump.
- Each requester presents a valid/ready byte stream with a last flag marking the end of its packet.
- The arbiter grants one requester per packet, forwards its bytes to the transmitter, then enforces an inter-packet idle gap counted in baud ticks.
- Sits between requester logic and the byte UART transmitter, in the same clk/baud_tick domain.

Parameters:
NUM_REQ, 4, number of requesters; legal range 1..4.
GAP_TICKS, 2, baud ticks of forced idle after each packet; 0 means no gap.
TIMEOUT_TICKS, 64, baud ticks of mid-packet stall before forced release; used only with the optional feature.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
baud_tick  in  1  one-cycle pulse per UART bit period
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  marks the final byte of a packet; sampled with req_valid
req_ready  out  NUM_REQ  per-requester byte accepted strobe
tx_valid  out  1  byte valid to the UART transmitter
tx_data  out  8  byte to the UART transmitter
tx_ready  in  1  transmitter can accept a byte this cycle
grant_id  out  2  index of the current or most recent grantee
busy  out  1  high in XFER or GAP
timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: state IDLE, grant_id 0, rr_ptr NUM_REQ-1, gap counter 0, timeout counter 0.
- Output reset values: tx_valid 0, tx_data 0, req_ready all 0, busy 0, timeout 0.
- State IDLE:
  - If any req_valid is high, register the grant and enter XFER on the next clk.
  - The grant is the first requester with req_valid high, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - On grant, rr_ptr <= granted index and grant_id <= granted index.
  - No requester is granted in the cycle req_valid first rises.
- Latency: req_valid rises in cycle 0 -> grant registered at the cycle-1 edge -> tx_valid visible in cycle 1.
- State XFER, with g = grant_id:
  - tx_valid = req_valid[g].
  - tx_data = req_data[g] (combinational mux); tx_data is 0 outside XFER.
  - req_ready[g] = tx_ready; all other req_ready bits are 0.
  - A byte transfers when tx_valid && tx_ready.
  - A transfer with req_last[g] high moves the block to GAP on the next clk.
  - The grant is held across any number of stall cycles with req_valid[g] low.
  - Other requesters' req_valid are ignored until the packet ends.
- State GAP:
  - All req_ready are 0 and tx_valid is 0.
  - The gap counter loads GAP_TICKS on entry and decrements on each baud_tick; leave for IDLE when it reaches 0.
  - With GAP_TICKS=0, GAP lasts exactly one cycle.
  - The block returns to IDLE, not directly to XFER, so a new arbitration costs one cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Single-byte packet (req_last on the first byte) is legal.
- NUM_REQ=1: always grant 0; the GAP still applies.
- grant_id keeps its last value through GAP and IDLE.
- busy = (state != IDLE).
- Mid-operation reset: returns to IDLE immediately; no partial packet is resumed.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - In XFER, a counter increments on each baud_tick while req_valid[g] is low.
  - The counter clears on any cycle with req_valid[g] high, and on leaving XFER.
  - On reaching TIMEOUT_TICKS, the block pulses timeout for one cycle and enters GAP; the packet is abandoned.
- Undefined:
  - No counter; the grant is held indefinitely.
  - timeout is tied to 0.

Test Plan:
- Single-requester packet:
  - Stimulus: req 1 sends 0x50,0x4F,0x4C,0x4F with last on 0x4F; tx_ready is held high.
  - Response: grant_id=1 and tx_valid asserted 1 cycle after req_valid; 4 handshakes carry exactly those bytes in order; busy drops after GAP_TICKS=2 baud ticks.
- Round robin: all 4 requesters send continuous 1-byte packets -> grant sequence 0,1,2,3,0,1; no requester granted twice in a row.
- Packet lock:
  - Stimulus: req 0 sends a 3-byte packet stalling valid low for 10 cycles mid-packet; req 2 is valid throughout.
  - Response: req_ready[2] stays 0 until req 0's last byte transfers.
- Back-pressure: tx_ready low 20 cycles while req_valid[g]=1 -> tx_data stable at the same byte, req_ready[g]=0, no byte lost or duplicated.
- Gap enforcement:
  - Stimulus: GAP_TICKS=2; req 3 becomes valid right after req 1's last byte.
  - Response: tx_valid stays 0 until 2 baud_ticks elapse plus 1 IDLE cycle.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_TICKS=4):
  - Stimulus: grantee stalls 4 baud ticks.
  - Response: timeout pulses once; block enters GAP; the next valid requester is granted afterward.
  - Without the macro: grant still held after 100 ticks and timeout stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte UART transmitter among up to four packet requesters.
// Optional mid-packet stall timeout is built in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   baud_tick,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [15:0] GAP_LD = 16'(GAP_TICKS);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_q, rr_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        busy_q, busy_d;

    logic [3:0]  valid_pad, last_pad, ready_pad;
    logic [31:0] data_pad;
    logic [1:0]  pick;
    logic        pick_ok;
    logic        cur_valid, cur_last;
    logic [7:0]  cur_data;
    logic        pkt_done;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_TICKS - 1);
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;
    logic        stall_expire;
`endif

    // Widen the requester buses to four lanes so grant_q can index them directly.
    always_comb begin
        valid_pad = '0;
        last_pad  = '0;
        data_pad  = '0;
        valid_pad[NUM_REQ-1:0]   = req_valid;
        last_pad[NUM_REQ-1:0]    = req_last;
        data_pad[8*NUM_REQ-1:0]  = req_data;
    end

    // Later loop iterations overwrite earlier ones, so walking the offsets downward
    // leaves the requester closest after rr_q as the winner.
    always_comb begin
        logic [1:0] idx;
        pick    = '0;
        pick_ok = 1'b0;
        idx     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = 2'((int'(rr_q) + i) % NUM_REQ);
            if (valid_pad[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    assign cur_valid = valid_pad[grant_q];
    assign cur_last  = last_pad[grant_q];
    assign cur_data  = data_pad[{grant_q, 3'b000} +: 8];
    assign pkt_done  = cur_valid && tx_ready && cur_last;

    always_comb begin
        ready_pad = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        if (state_q == S_XFER) begin
            ready_pad[grant_q] = tx_ready;
            tx_valid           = cur_valid;
            tx_data            = cur_data;
        end
    end

    assign req_ready = ready_pad[NUM_REQ-1:0];

`ifdef UART_ARB_TIMEOUT_EN
    assign stall_expire = !cur_valid && baud_tick && (to_cnt_q == TO_LAST);
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        gap_cnt_d = gap_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_ok) begin
                    state_d = S_XFER;
                    grant_d = pick;
                    rr_d    = pick;
                end
            end
            S_XFER: begin
                if (pkt_done) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LD;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (stall_expire) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LD;
                    timeout_d = 1'b1;
                end
`endif
            end
            S_GAP: begin
                // Leave on the tick that would take the count to zero, so the
                // idle time is exactly GAP_TICKS ticks before re-arbitration.
                if (gap_cnt_q == 16'd0 || (baud_tick && gap_cnt_q == 16'd1)) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else if (baud_tick) begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_XFER && state_d == S_XFER && !cur_valid) begin
            to_cnt_d = baud_tick ? to_cnt_q + 16'd1 : to_cnt_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            rr_q      <= 2'(NUM_REQ - 1);
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            gap_cnt_q <= gap_cnt_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes {grant, byte} expectations,
// a negedge monitor pops one per transmitter handshake.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        baud_tick;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    int n_checks  = 0;
    int n_errors  = 0;
    int to_pulses = 0;
    logic [9:0] exp_q[$];

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_TICKS(2), .TIMEOUT_TICKS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && tx_valid && tx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_byte: got grant %0d data %02h, expected no transfer", grant_id, tx_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, tx_data} !== e) begin
                    n_errors++;
                    $display("FAIL byte: got grant %0d data %02h, expected grant %0d data %02h",
                             grant_id, tx_data, e[9:8], e[7:0]);
                end
            end
        end
        if (rst_n && timeout) to_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]     = v;
        req_data[8*i +: 8] = d;
        req_last[i]      = l;
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic wait_empty(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        baud_tick = 1'b0;
        tx_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single-requester packet on req 1
        set_req(1, 1'b1, 8'h50, 1'b0);
        push(2'd1, 8'h50); push(2'd1, 8'h4F); push(2'd1, 8'h4C); push(2'd1, 8'h4F);
        @(negedge clk);
        chk("no_grant_first_cycle", tx_valid, 0);
        chk("idle_not_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("pkt1_grant_id", grant_id, 1);
        chk("pkt1_tx_valid", tx_valid, 1);
        chk("pkt1_req_ready", req_ready, 4'b0010);
        tick(); set_req(1, 1'b1, 8'h4F, 1'b0);
        tick(); set_req(1, 1'b1, 8'h4C, 1'b0);
        tick(); set_req(1, 1'b1, 8'h4F, 1'b1);
        tick(); set_req(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("pkt1_gap_busy", busy, 1);
        chk("pkt1_gap_tx_valid", tx_valid, 0);
        chk("pkt1_bytes_done", exp_q.size(), 0);
        baud_tick = 1'b1;
        tick(); baud_tick = 1'b0;
        @(negedge clk);
        chk("gap_after_one_tick", busy, 1);
        tick();
        @(negedge clk);
        chk("gap_no_tick", busy, 1);
        baud_tick = 1'b1;
        tick(); baud_tick = 1'b0;
        @(negedge clk);
        chk("gap_done_busy", busy, 0);
        chk("gap_keeps_grant", grant_id, 1);

        // Round robin with all requesters sending one-byte packets
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
        push(2'd0, 8'hA0); push(2'd1, 8'hA1); push(2'd2, 8'hA2);
        push(2'd3, 8'hA3); push(2'd0, 8'hA0); push(2'd1, 8'hA1);
        baud_tick = 1'b1;
        wait_empty("rr_drained", 200);
        req_valid = '0;
        repeat (4) tick();
        baud_tick = 1'b0;
        @(negedge clk);
        chk("rr_idle", busy, 0);
        chk("rr_last_grant", grant_id, 1);

        // Packet lock and back-pressure: req 0 holds the grant while req 2 waits
        do_reset();
        set_req(0, 1'b1, 8'h11, 1'b0);
        set_req(2, 1'b1, 8'h77, 1'b1);
        push(2'd0, 8'h11); push(2'd0, 8'h22); push(2'd0, 8'h33); push(2'd2, 8'h77);
        tick();
        @(negedge clk);
        chk("lock_grant", grant_id, 0);
        chk("lock_ready0", req_ready, 4'b0001);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("lock_stall_ready", req_ready, 4'b0001);
            chk("lock_stall_tx_valid", tx_valid, 0);
            tick();
        end
        set_req(0, 1'b1, 8'h22, 1'b0);
        tx_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_tx_data", tx_data, 8'h22);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_tx_valid", tx_valid, 1);
            tick();
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", req_ready, 4'b0001);
        tick(); set_req(0, 1'b1, 8'h33, 1'b1);
        @(negedge clk);
        chk("lock_last_ready", req_ready, 4'b0001);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0);
        baud_tick = 1'b1;
        wait_empty("lock_drained", 50);
        set_req(2, 1'b0, 8'h00, 1'b0);
        repeat (4) tick();
        baud_tick = 1'b0;
        @(negedge clk);
        chk("lock_idle", busy, 0);
        chk("lock_second_grant", grant_id, 2);

        // Gap enforcement: req 3 waits two baud ticks plus one idle cycle
        set_req(1, 1'b1, 8'h5A, 1'b1);
        push(2'd1, 8'h5A); push(2'd3, 8'hC3);
        tick();
        @(negedge clk);
        chk("gap_test_grant1", grant_id, 1);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b1, 8'hC3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("gap_hold_pre", tx_valid, 0);
            tick();
        end
        baud_tick = 1'b1;
        @(negedge clk);
        chk("gap_hold_tick1", tx_valid, 0);
        tick(); baud_tick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("gap_hold_mid", tx_valid, 0);
            tick();
        end
        baud_tick = 1'b1;
        @(negedge clk);
        chk("gap_hold_tick2", tx_valid, 0);
        tick(); baud_tick = 1'b0;
        @(negedge clk);
        chk("gap_idle_tx_valid", tx_valid, 0);
        chk("gap_idle_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("gap_next_tx_valid", tx_valid, 1);
        chk("gap_next_grant", grant_id, 3);
        tick();
        set_req(3, 1'b0, 8'h00, 1'b0);
        baud_tick = 1'b1;
        repeat (4) tick();
        baud_tick = 1'b0;
        chk("gap_drained", exp_q.size(), 0);

        // Mid-packet stall on req 0 with req 1 waiting
        set_req(0, 1'b1, 8'h0F, 1'b1);
        tx_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("stall_grant", grant_id, 0);
        tick();
        set_req(0, 1'b0, 8'h0F, 1'b1);
        tx_ready = 1'b1;
        set_req(1, 1'b1, 8'hE1, 1'b1);
        to_pulses = 0;
        baud_tick = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        push(2'd1, 8'hE1);
        wait_empty("to_next_grant", 40);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (4) tick();
        chk("to_pulse_count", to_pulses, 1);
`else
        repeat (200) tick();
        @(negedge clk);
        chk("hold_no_timeout", to_pulses, 0);
        chk("hold_busy", busy, 1);
        chk("hold_grant", grant_id, 0);
        chk("hold_ready", req_ready, 4'b0001);
        tick();
        push(2'd0, 8'h0F);
        set_req(0, 1'b1, 8'h0F, 1'b1);
        wait_empty("hold_release", 10);
        set_req(0, 1'b0, 8'h00, 1'b0);
        push(2'd1, 8'hE1);
        wait_empty("hold_next_grant", 20);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (4) tick();
`endif
        baud_tick = 1'b0;
        @(negedge clk);
        chk("stall_final_idle", busy, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
